div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the EX stage of the five-stage MIPS pipeline. It consumes the EX-stage divide controls (`isdivE`, `signeddivE`) together with the forwarded EX operands. It raises a stall request to the hazard unit for the duration of the operation. It delivers the `{HI, LO}` = `{remainder, quotient}` pair, which is carried down the pipeline to the HI/LO write in WB.

---
 rtl/div_unit.sv | 118 +++++++++++
 tb/tb_div_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring integer divider for the EX stage.
// Produces {remainder, quotient} after WIDTH iterations and requests a
// pipeline stall from the cycle the divide is accepted until DONE.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cancel,
  output logic               stall_div,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] w;
  logic [WIDTH-1:0]   b_abs;
  logic               qs;
  logic               rs;

  logic [WIDTH-1:0]   a_abs_in;
  logic [WIDTH-1:0]   b_abs_in;
  logic [2*WIDTH-1:0] w_sh;
  logic [WIDTH:0]     t;
  logic [2*WIDTH-1:0] w_step;
  logic [WIDTH-1:0]   q_fin;
  logic [WIDTH-1:0]   r_fin;

  // Operand magnitudes at issue; DIVU passes the raw bit patterns through.
  always_comb begin
    a_abs_in = a;
    b_abs_in = b;
    if (signed_div && a[WIDTH-1]) a_abs_in = -a;
    if (signed_div && b[WIDTH-1]) b_abs_in = -b;
  end

  // One restoring step: shift, trial subtract, keep the difference if it fits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_step = '0;
    w_sh   = {w[2*WIDTH-2:0], 1'b0};
    t      = {1'b0, w_sh[2*WIDTH-1:WIDTH]} - {1'b0, b_abs};
    if (t[WIDTH]) w_step = w_sh;
    else          w_step = {t[WIDTH-1:0], w_sh[WIDTH-1:1], 1'b1};
  end

  // Sign fix-up of the final step, applied as the result is loaded.
  always_comb begin
    q_fin = qs ? -w_step[WIDTH-1:0]       : w_step[WIDTH-1:0];
    r_fin = rs ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];
  end

  // Stall from the accepting IDLE cycle through the last BUSY cycle.
  always_comb begin
    stall_div = ((state == IDLE) && start && !cancel) || (state == BUSY);
  end

  // Divider FSM with registered ready/result; cancel beats start in every state.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      w      <= '0;
      b_abs  <= '0;
      qs     <= 1'b0;
      rs     <= 1'b0;
      ready  <= 1'b0;
      result <= '0;
    end else if (cancel) begin
      state <= IDLE;
      ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (start) begin
            w     <= {{WIDTH{1'b0}}, a_abs_in};
            b_abs <= b_abs_in;
            qs    <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            rs    <= signed_div & a[WIDTH-1];
            count <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          w     <= w_step;
          count <= count + 1'b1;
          if (count == LAST_COUNT) begin
            result <= {r_fin, q_fin};
            ready  <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          // start is still high for the retiring instruction; do not re-trigger.
          ready <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors for div_unit with a queue-based scoreboard.
// Stimulus pushes the expected {remainder, quotient}; a monitor pops on ready.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        stall_div;
  logic        ready;
  logic [63:0] result;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .cancel(cancel),
    .stall_div(stall_div), .ready(ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_ready: got result 0x%0h expected no ready", result);
        end else begin
          check("result", result, exp_q.pop_front());
        end
      end
    end
  end

  // Issue one divide, scramble operands after capture, and time the stall.
  task automatic run_div(input logic s, input logic [31:0] ai, input logic [31:0] bi,
                         input logic [63:0] exp, input bit keep_start);
    int cyc;
    int stalls;
    @(posedge clk); #1;
    start = 1'b1; signed_div = s; a = ai; b = bi;
    exp_q.push_back(exp);
    cyc = 0;
    stalls = 0;
    @(negedge clk);
    while (ready !== 1'b1 && cyc < 40) begin
      if (stall_div === 1'b1) stalls++;
      @(posedge clk); #1;
      a = ~ai; b = bi ^ 32'h0000_00FF; signed_div = ~s;
      cyc++;
      @(negedge clk);
    end
    check("ready_cycle", 64'(cyc), 64'd33);
    check("stall_cycles", 64'(stalls), 64'd33);
    check("stall_in_done", {63'd0, stall_div}, 64'd0);
    if (!keep_start) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  initial begin
    int cyc;
    int stalls;
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; a = '0; b = '0; cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_stall", {63'd0, stall_div}, 64'd0);
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_result", result, 64'd0);

    // Basic unsigned and signed cases.
    run_div(1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},        1'b0);
    run_div(1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    run_div(1'b1, 32'd7,          32'hFFFF_FFFE, {32'd1,        32'hFFFF_FFFD}, 1'b0);
    run_div(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'd0,        32'h8000_0000}, 1'b0);
    // Divide by zero.
    run_div(1'b0, 32'd5,          32'd0,        {32'd5,        32'hFFFF_FFFF}, 1'b0);
    run_div(1'b1, 32'hFFFF_FFF9,  32'd0,        {32'hFFFF_FFF9, 32'd1},        1'b0);

    // Cancel in BUSY cycle 10: back to IDLE, no ready, result untouched.
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
    repeat (10) @(posedge clk);
    #1 cancel = 1'b1; start = 1'b0;
    @(negedge clk);
    check("stall_busy_at_cancel", {63'd0, stall_div}, 64'd1);
    @(posedge clk); #1 cancel = 1'b0;
    @(negedge clk);
    check("cancel_stall", {63'd0, stall_div}, 64'd0);
    check("cancel_ready", {63'd0, ready}, 64'd0);
    check("cancel_result", result, {32'hFFFF_FFF9, 32'd1});
    stalls = 0;
    repeat (40) begin
      @(negedge clk);
      if (stall_div === 1'b1) stalls++;
    end
    check("post_cancel_idle", 64'(stalls), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0);

    // Cancel and start together in IDLE: nothing starts.
    @(posedge clk); #1;
    start = 1'b1; cancel = 1'b1; a = 32'd20; b = 32'd6;
    @(negedge clk);
    check("cancel_start_stall", {63'd0, stall_div}, 64'd0);
    @(posedge clk); #1 start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    check("cancel_start_idle", {63'd0, stall_div}, 64'd0);

    // Back-to-back divides with start held through DONE.
    run_div(1'b0, 32'd20,         32'd6, {32'd2, 32'd3},          1'b1);
    run_div(1'b0, 32'hFFFF_FFFF,  32'd1, {32'd0, 32'hFFFF_FFFF},  1'b0);

    // Reset in BUSY cycle 5, start held: fresh operation afterwards.
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; a = 32'd20; b = 32'd6;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; a = 32'd45; b = 32'd6;
    exp_q.push_back({32'd3, 32'd7});
    @(negedge clk);
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_restart_stall", {63'd0, stall_div}, 64'd1);
    cyc = 6;
    while (ready !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      @(negedge clk);
    end
    check("rst_restart_cycle", 64'(cyc), 64'd39);
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
